wave_table_writer: RTL and testbench

//   Generates one full 256-entry, 8-bit waveform table (sine-approx / triangle / square / sawtooth)
//   and streams it into the write port of a wavetable RAM, one entry per accepted cycle.
//   It is the writer for the DDS table read path: the DDS reads addr->sample, this block fills addr<-sample.

---
 rtl/wave_table_writer.sv | 186 ++++++++++++++++++
 tb/tb_wave_table_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_table_writer.sv
// wave_table_writer: fills a 256 x 8 wavetable RAM with one generated waveform
// (sine-approx, triangle, square or sawtooth), scaled by amp, one entry per
// accepted write. Start/busy/done handshake, wr_ready backpressure.
// Optional build macro WAVE_WR_CHECKSUM_EN adds a 16-bit running sum of the
// accepted write data.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; outputs idle
// ST_WRITE | presenting waddr/wdata with we=1 until every entry is accepted
// ST_DONE  | one-cycle done pulse, then back to idle
module wave_table_writer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int SQ_DUTY = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        wave_sel,
  input  logic [DATA_W-1:0] amp,
  input  logic              wr_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
`ifdef WAVE_WR_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  if (ADDR_W != 8 || DATA_W != 8) begin : g_bad_param
    $error("wave_table_writer supports only ADDR_W=8 and DATA_W=8");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  amp_q, amp_d;
  logic        we_q, we_d;
  logic [7:0]  waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_ok;
  logic        accept;
  logic        last_accept;

  // Raw waveform R(a), then scaled by (amp+1)/256 keeping the upper product byte.
  function automatic logic [7:0] sample_f(input logic [1:0] sel, input logic [7:0] amp_v,
                                          input logic [7:0] a);
    logic [6:0]  p;
    logic [13:0] prod;
    logic [7:0]  q;
    logic [6:0]  t;
    logic [7:0]  r;
    logic [15:0] scaled;
    p    = a[6:0];
    prod = 14'(p) * 14'(7'd127 - p);
    q    = 8'(prod >> 5);
    t    = a[7] ? ~a[6:0] : a[6:0];
    case (sel)
      2'b00:   r = a[7] ? (8'd128 - q) : (8'd128 + q);
      2'b01:   r = {t, a[7]};
      2'b10:   r = (int'(a) < SQ_DUTY) ? 8'hFF : 8'h00;
      default: r = a;
    endcase
    scaled = 16'(r) * (16'(amp_v) + 16'd1);
    return 8'(scaled >> 8);
  endfunction

  assign start_ok    = start & ~abort;
  assign accept      = we_q & wr_ready;
  assign last_accept = accept & (waddr_q == 8'hFF);

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      amp_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      amp_q   <= amp_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: abort beats both start and a same-edge final accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_WRITE;
      ST_WRITE: begin
        if (abort)            state_d = ST_IDLE;
        else if (last_accept) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next register values for the write port and handshake; held while wr_ready is low.
  always_comb begin
    sel_d   = sel_q;
    amp_d   = amp_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          sel_d   = wave_sel;
          amp_d   = amp;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          waddr_d = 8'h00;
          wdata_d = sample_f(wave_sel, amp, 8'h00);
        end
      end
      ST_WRITE: begin
        if (abort) begin
          we_d    = 1'b0;
          busy_d  = 1'b0;
          waddr_d = 8'h00;
          wdata_d = 8'h00;
        end else if (last_accept) begin
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          waddr_d = 8'h00;
          wdata_d = 8'h00;
        end else if (accept) begin
          waddr_d = waddr_q + 8'd1;
          wdata_d = sample_f(sel_q, amp_q, waddr_q + 8'd1);
        end
      end
      default: begin
        we_d   = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef WAVE_WR_CHECKSUM_EN
  logic [15:0] cks_q, cks_d;

  // Running sum of accepted data; cleared when a new table is started.
  always_comb begin
    cks_d = cks_q;
    if (state_q == ST_IDLE && start_ok) cks_d = 16'h0000;
    else if (accept)                    cks_d = cks_q + 16'(wdata_q);
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) cks_q <= 16'h0000;
    else     cks_q <= cks_d;
  end

  assign checksum = cks_q;
`endif

endmodule

// File: tb/tb_wave_table_writer.sv
// Self-checking bench for wave_table_writer: table-driven entry checks plus
// hand-written sequences for timing, backpressure, abort, start-ignore and reset.
module tb_wave_table_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] wave_sel;
  logic [7:0] amp;
  logic       wr_ready;
  logic       we;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
`ifdef WAVE_WR_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [256];

  wave_table_writer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .wave_sel (wave_sel),
    .amp      (amp),
    .wr_ready (wr_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done)
`ifdef WAVE_WR_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] amp;
    bit         rnd;
    int         addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [29];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one full table; captures accepted writes into mem.
  task automatic run_table(input logic [1:0] s, input logic [7:0] a, input bit rnd,
                           output int edges);
    int   accepts;
    int   exp_addr;
    bit   order_ok;
    bit   stable_ok;
    bit   got_done;
    bit   pwe;
    bit   pready;
    logic [7:0] pa;
    logic [7:0] pd;
    wave_sel = s;
    amp      = a;
    wr_ready = 1'b1;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wave_sel = ~s;
    amp      = ~a;
    check("first_write", {23'd0, we, busy, waddr}, {23'd0, 1'b1, 1'b1, 8'h00});
    edges = 0; accepts = 0; exp_addr = 0;
    order_ok = 1'b1; stable_ok = 1'b1; got_done = 1'b0;
    while (!got_done && edges < 3000) begin
      wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pwe = we; pa = waddr; pd = wdata; pready = wr_ready;
      if (we && wr_ready) begin
        if (waddr != exp_addr[7:0]) order_ok = 1'b0;
        mem[waddr] = wdata;
        accepts++;
        exp_addr++;
      end
      step();
      edges++;
      if (pwe && !pready && (waddr != pa || wdata != pd || !we)) stable_ok = 1'b0;
      if (done) got_done = 1'b1;
    end
    wr_ready = 1'b1;
    check("done_seen", 32'(got_done), 32'd1);
    check("accept_count", 32'(accepts), 32'd256);
    check("addr_order", 32'(order_ok), 32'd1);
    if (rnd) check("hold_on_stall", 32'(stable_ok), 32'd1);
    check("done_outputs", {22'd0, we, busy, waddr}, 32'd0);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int   edges;
    int   ndone;
    bit   all_ok;
    logic [7:0] a_before;

    vecs[0]  = '{2'b11, 8'd255, 1'b0, 0,   8'd0};
    vecs[1]  = '{2'b11, 8'd255, 1'b0, 1,   8'd1};
    vecs[2]  = '{2'b11, 8'd255, 1'b0, 100, 8'd100};
    vecs[3]  = '{2'b11, 8'd255, 1'b0, 255, 8'd255};
    vecs[4]  = '{2'b11, 8'd127, 1'b0, 200, 8'd100};
    vecs[5]  = '{2'b11, 8'd127, 1'b0, 255, 8'd127};
    vecs[6]  = '{2'b10, 8'd255, 1'b0, 0,   8'd255};
    vecs[7]  = '{2'b10, 8'd255, 1'b0, 127, 8'd255};
    vecs[8]  = '{2'b10, 8'd255, 1'b0, 128, 8'd0};
    vecs[9]  = '{2'b10, 8'd255, 1'b0, 255, 8'd0};
    vecs[10] = '{2'b10, 8'd127, 1'b0, 0,   8'd127};
    vecs[11] = '{2'b10, 8'd127, 1'b0, 127, 8'd127};
    vecs[12] = '{2'b10, 8'd127, 1'b0, 128, 8'd0};
    vecs[13] = '{2'b01, 8'd255, 1'b1, 0,   8'd0};
    vecs[14] = '{2'b01, 8'd255, 1'b1, 64,  8'd128};
    vecs[15] = '{2'b01, 8'd255, 1'b1, 127, 8'd254};
    vecs[16] = '{2'b01, 8'd255, 1'b1, 128, 8'd255};
    vecs[17] = '{2'b01, 8'd255, 1'b1, 255, 8'd1};
    vecs[18] = '{2'b00, 8'd255, 1'b0, 0,   8'd128};
    vecs[19] = '{2'b00, 8'd255, 1'b0, 32,  8'd223};
    vecs[20] = '{2'b00, 8'd255, 1'b0, 64,  8'd254};
    vecs[21] = '{2'b00, 8'd255, 1'b0, 128, 8'd128};
    vecs[22] = '{2'b00, 8'd255, 1'b0, 160, 8'd33};
    vecs[23] = '{2'b00, 8'd255, 1'b0, 192, 8'd2};
    vecs[24] = '{2'b00, 8'd0,   1'b0, 64,  8'd0};
    vecs[25] = '{2'b00, 8'd0,   1'b0, 0,   8'd0};
    vecs[26] = '{2'b11, 8'd0,   1'b0, 255, 8'd0};
    vecs[27] = '{2'b01, 8'd127, 1'b0, 128, 8'd127};
    vecs[28] = '{2'b01, 8'd127, 1'b0, 127, 8'd127};

    rst = 1'b1; start = 1'b0; abort = 1'b0; wave_sel = 2'b00; amp = 8'd0; wr_ready = 1'b1;
    step(); step();
    check("reset_outputs", {13'd0, we, busy, done, waddr, wdata}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_after_reset", {29'd0, we, busy, done}, 32'd0);

    // Sawtooth full run: exact latency and every entry equals its address.
    run_table(2'b11, 8'd255, 1'b0, edges);
    check("saw_latency", 32'(edges), 32'd256);
    all_ok = 1'b1;
    for (int k = 0; k < 256; k++) if (mem[k] != 8'(k)) all_ok = 1'b0;
    check("saw_all_entries", 32'(all_ok), 32'd1);

    // Table-driven entry checks; a new table is written whenever the config changes.
    for (int i = 0; i < 29; i++) begin
      if (i == 0 || vecs[i].sel != vecs[i-1].sel || vecs[i].amp != vecs[i-1].amp ||
          vecs[i].rnd != vecs[i-1].rnd)
        run_table(vecs[i].sel, vecs[i].amp, vecs[i].rnd, edges);
      check($sformatf("vec%0d_sel%0d_amp%0d_a%0d", i, vecs[i].sel, vecs[i].amp, vecs[i].addr),
            32'(mem[vecs[i].addr]), 32'(vecs[i].exp));
    end

    // Abort mid-table at waddr=100.
    wave_sel = 2'b00; amp = 8'd255; wr_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 300 && waddr != 8'd100; c++) step();
    check("abort_reach", 32'(waddr), 32'd100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_outputs", {22'd0, we, busy, waddr}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 300; c++) begin
      if (done) ndone++;
      step();
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    for (int k = 0; k < 256; k++) mem[k] = 8'h55;
    run_table(2'b00, 8'd255, 1'b0, edges);
    check("restart_latency", 32'(edges), 32'd256);
    check("restart_a64", 32'(mem[64]), 32'd254);
    check("restart_a192", 32'(mem[192]), 32'd2);

    // start and abort on the same edge in idle: stays idle.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {30'd0, we, busy}, 32'd0);

    // start during WRITE is ignored; exactly one done.
    wave_sel = 2'b11; amp = 8'd255; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 300 && waddr != 8'd20; c++) step();
    a_before = waddr;
    wave_sel = 2'b10; start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored", {16'd0, waddr, wdata}, {16'd0, a_before + 8'd1, a_before + 8'd1});
    ndone = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (done) ndone++;
    end
    check("single_done", 32'(ndone), 32'd1);

    // Reset mid-write at waddr=50.
    wave_sel = 2'b11; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 300 && waddr != 8'd50; c++) step();
    check("rst_reach", 32'(waddr), 32'd50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_outputs", {13'd0, we, busy, done, waddr, wdata}, 32'd0);
`ifdef WAVE_WR_CHECKSUM_EN
    check("rst_checksum", 32'(checksum), 32'd0);
`endif
    ndone = 0;
    for (int c = 0; c < 300; c++) begin
      if (done || we) ndone++;
      step();
    end
    check("rst_stays_idle", 32'(ndone), 32'd0);

`ifdef WAVE_WR_CHECKSUM_EN
    run_table(2'b11, 8'd255, 1'b0, edges);
    check("checksum_saw", 32'(checksum), 32'h7F80);
    step(); step();
    check("checksum_stable", 32'(checksum), 32'h7F80);
    run_table(2'b10, 8'd255, 1'b1, edges);
    check("checksum_square", 32'(checksum), 32'h7F80);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
